contador_passageiros: RTL
=========================

// Module: contador_passageiros
// PURPOSE
// Counts elevator occupants from two raw door sensors: entry and exit.
// Drives the 2-bit occupancy code capacidade_atual consumed by controle_capacidade.
// Input chain: 2-FF synchronizer, debounce FSM, then rising-edge event.
// Event chain: event updates a saturating occupancy counter, which is decoded
// to a registered level code.
// PARAMETERS
// CAP_MAX          8   occupancy limit; above it the code is 2'b11 (exceeded)
// CONT_MAX         15  hardware counter ceiling; saturates here
// CONT_W           4   counter width; must satisfy 2**CONT_W-1 >= CONT_MAX
// DEBOUNCE_CICLOS  4   consecutive stable synchronized samples to accept a level (>=1)
// PORTS
// clk               in   1       system clock
// reset             in   1       synchronous, active-high
// sensor_entrada    in   1       raw entry sensor, asynchronous, may bounce
// sensor_saida      in   1       raw exit sensor, asynchronous, may bounce
// porta_aberta      in   1       1 = door open; events are counted only while 1
// limpar_erro       in   1       1-cycle pulse; clears erro_contagem
// ocupacao          out  CONT_W  current occupant count (registered)
// capacidade_atual  out  2       level code to controle_capacidade (registered)
// erro_contagem     out  1       sticky error flag
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset values: ocupacao=0, capacidade_atual=2'b00, erro_contagem=0.
//   Synchronizers are cleared; both filters enter AGUARDA_REPOUSO.
// - Filter FSM, one per sensor, runs on the synchronized input s; cnt counts stable samples.
//   AGUARDA_REPOUSO: s=0 for DEBOUNCE_CICLOS samples -> OCIOSO. A sensor held high
//     across reset is therefore never counted until it is released.
//   OCIOSO: s=1 -> FILTRA_ALTA (cnt=1).
//   FILTRA_ALTA: s=0 -> OCIOSO. cnt reaching DEBOUNCE_CICLOS -> ATIVO, with a
//     1-cycle pulse on that transition.
//   ATIVO: s=0 -> FILTRA_BAIXA.
//   FILTRA_BAIXA: s=1 -> ATIVO. DEBOUNCE_CICLOS lows -> OCIOSO.
// - Latency: raw input high sampled at edge 1 -> ATIVO at edge 2+DEBOUNCE_CICLOS.
//   ocupacao updates at edge 3+DEBOUNCE_CICLOS; capacidade_atual at edge 4+DEBOUNCE_CICLOS.
// - Counter update, on the edge following the pulses (pe = entry pulse, ps = exit pulse):
//   porta_aberta=0 and any pulse: ocupacao holds; erro_contagem <= 1.
//   pe&ps: ocupacao holds (net zero); no error.
//   pe only: at CONT_MAX, holds and sets error; else +1.
//   ps only: at 0, holds and sets error; else -1.
// - Level decode, registered from ocupacao:
//   0 -> 2'b00
//   1..CAP_MAX/2 (integer division) -> 2'b01
//   CAP_MAX/2+1..CAP_MAX -> 2'b10
//   >CAP_MAX -> 2'b11
// - erro_contagem: a set in the same cycle as limpar_erro wins. Otherwise limpar_erro clears it.
// - Reset asserted mid-filter or mid-update discards every pending event.
// STRUCTURE
// - Shared include pacote_elevador.vh holds:
//   CAP_VAZIO=2'b00, CAP_BAIXA=2'b01, CAP_ALTA=2'b10, CAP_EXCEDIDA=2'b11;
//   filter state encodings (3 bits).
// - Sub-module filtro_sensor (sync + debounce FSM + pulse), instantiated twice.
// - Top level holds the counter, the error flag and the level decode.
// TESTING
// 1 Reset with sensors low; 4 clean entries (porta_aberta=1, 10-cycle pulses)
//   -> ocupacao=4, capacidade_atual=01; each code is seen 8 edges after its input rose.
// 2 9 entries -> code 10 at count 5, 11 at count 9. Then 1 exit -> ocupacao=8, code 10.
// 3 Entry input toggling every cycle for 20 cycles, then low -> ocupacao unchanged.
//   Input high 3 cycles only -> no count.
// 4 Entry and exit pulses aligned to the same edge -> ocupacao unchanged, erro=0.
//   Exit at ocupacao=0 -> stays 0, erro=1.
//   limpar_erro -> erro=0.
// 5 Entry with porta_aberta=0 -> ocupacao holds, erro=1.
//   16 entries from 0 -> saturates at 15, erro=1.
// 6 Sensor held high across a reset pulse, then kept high 20 cycles
//   -> ocupacao=0. Release, press again -> ocupacao=1.

Source files
------------

// File: rtl/contador_passageiros_pkg.sv
// Shared definitions for the elevator occupancy counter: level codes,
// debounce filter state encoding and the occupancy-to-level decode.
package contador_passageiros_pkg;

    localparam logic [1:0] CAP_VAZIO    = 2'b00;
    localparam logic [1:0] CAP_BAIXA    = 2'b01;
    localparam logic [1:0] CAP_ALTA     = 2'b10;
    localparam logic [1:0] CAP_EXCEDIDA = 2'b11;

    typedef enum logic [2:0] {
        AGUARDA_REPOUSO = 3'd0,
        OCIOSO          = 3'd1,
        FILTRA_ALTA     = 3'd2,
        ATIVO           = 3'd3,
        FILTRA_BAIXA    = 3'd4
    } estado_filtro_t;

    // Half of the limit (integer division) splits the "low" and "high" bands.
    function automatic logic [1:0] decodifica_nivel(input int unsigned valor,
                                                    input int unsigned cap_max);
        logic [1:0] nivel;
        if (valor == 0)
            nivel = CAP_VAZIO;
        else if (valor <= cap_max / 2)
            nivel = CAP_BAIXA;
        else if (valor <= cap_max)
            nivel = CAP_ALTA;
        else
            nivel = CAP_EXCEDIDA;
        return nivel;
    endfunction

endpackage

// File: rtl/contador_passageiros_filtro_sensor.sv
// One door sensor conditioner: 2-FF synchronizer, debounce FSM and a
// single-cycle pulse when a stable high level is accepted.
module filtro_sensor
    import contador_passageiros_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor,
    output logic pulso
);

    localparam int CNT_W = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(DEBOUNCE_CICLOS - 1);
    localparam logic [CNT_W-1:0] CNT_UM     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam bit AMOSTRA_UNICA = (DEBOUNCE_CICLOS == 1);

    logic sinc_a;
    logic sinc_b;

    estado_filtro_t estado;
    estado_filtro_t estado_prox;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_prox;
    logic pulso_prox;

    always_ff @(posedge clk) begin
        if (reset) begin
            sinc_a <= 1'b0;
            sinc_b <= 1'b0;
        end else begin
            sinc_a <= sensor;
            sinc_b <= sinc_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado <= AGUARDA_REPOUSO;
            cnt    <= CNT_ZERO;
            pulso  <= 1'b0;
        end else begin
            estado <= estado_prox;
            cnt    <= cnt_prox;
            pulso  <= pulso_prox;
        end
    end

    // cnt holds how many consecutive qualifying samples have been seen,
    // including the one that caused entry into the current filter state.
    always_comb begin
        estado_prox = estado;
        cnt_prox    = cnt;
        pulso_prox  = 1'b0;
        unique case (estado)
            AGUARDA_REPOUSO: begin
                if (sinc_b) begin
                    cnt_prox = CNT_ZERO;
                end else if (cnt == CNT_ULTIMO) begin
                    estado_prox = OCIOSO;
                    cnt_prox    = CNT_ZERO;
                end else begin
                    cnt_prox = cnt + CNT_UM;
                end
            end
            OCIOSO: begin
                if (sinc_b) begin
                    if (AMOSTRA_UNICA) begin
                        estado_prox = ATIVO;
                        pulso_prox  = 1'b1;
                    end else begin
                        estado_prox = FILTRA_ALTA;
                        cnt_prox    = CNT_UM;
                    end
                end
            end
            FILTRA_ALTA: begin
                if (!sinc_b) begin
                    estado_prox = OCIOSO;
                    cnt_prox    = CNT_ZERO;
                end else if (cnt == CNT_ULTIMO) begin
                    estado_prox = ATIVO;
                    cnt_prox    = CNT_ZERO;
                    pulso_prox  = 1'b1;
                end else begin
                    cnt_prox = cnt + CNT_UM;
                end
            end
            ATIVO: begin
                if (!sinc_b) begin
                    if (AMOSTRA_UNICA) begin
                        estado_prox = OCIOSO;
                    end else begin
                        estado_prox = FILTRA_BAIXA;
                        cnt_prox    = CNT_UM;
                    end
                end
            end
            FILTRA_BAIXA: begin
                if (sinc_b) begin
                    estado_prox = ATIVO;
                    cnt_prox    = CNT_ZERO;
                end else if (cnt == CNT_ULTIMO) begin
                    estado_prox = OCIOSO;
                    cnt_prox    = CNT_ZERO;
                end else begin
                    cnt_prox = cnt + CNT_UM;
                end
            end
            default: begin
                estado_prox = AGUARDA_REPOUSO;
                cnt_prox    = CNT_ZERO;
            end
        endcase
    end

endmodule

// File: rtl/contador_passageiros.sv
// Elevator occupancy counter: filters entry/exit sensors, keeps a saturating
// occupant count, a sticky error flag and a registered capacity level code.
module contador_passageiros
    import contador_passageiros_pkg::*;
#(
    parameter int CAP_MAX         = 8,
    parameter int CONT_MAX        = 15,
    parameter int CONT_W          = 4,
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sensor_entrada,
    input  logic              sensor_saida,
    input  logic              porta_aberta,
    input  logic              limpar_erro,
    output logic [CONT_W-1:0] ocupacao,
    output logic [1:0]        capacidade_atual,
    output logic              erro_contagem
);

    localparam logic [CONT_W-1:0] LIMITE = CONT_W'(CONT_MAX);
    localparam logic [CONT_W-1:0] UM     = CONT_W'(1);
    localparam logic [CONT_W-1:0] ZERO   = '0;

    logic pulso_entrada;
    logic pulso_saida;
    logic [CONT_W-1:0] ocupacao_prox;
    logic erro_evento;
    logic [1:0] nivel_prox;

    filtro_sensor #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_filtro_entrada (
        .clk   (clk),
        .reset (reset),
        .sensor(sensor_entrada),
        .pulso (pulso_entrada)
    );

    filtro_sensor #(
        .DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)
    ) u_filtro_saida (
        .clk   (clk),
        .reset (reset),
        .sensor(sensor_saida),
        .pulso (pulso_saida)
    );

    // Any event seen with the door closed is suspicious: count nothing, flag it.
    always_comb begin
        ocupacao_prox = ocupacao;
        erro_evento   = 1'b0;
        if (pulso_entrada || pulso_saida) begin
            if (!porta_aberta) begin
                erro_evento = 1'b1;
            end else begin
                unique case ({pulso_entrada, pulso_saida})
                    2'b10: begin
                        if (ocupacao == LIMITE)
                            erro_evento = 1'b1;
                        else
                            ocupacao_prox = ocupacao + UM;
                    end
                    2'b01: begin
                        if (ocupacao == ZERO)
                            erro_evento = 1'b1;
                        else
                            ocupacao_prox = ocupacao - UM;
                    end
                    default: ocupacao_prox = ocupacao;
                endcase
            end
        end
    end

    always_comb begin
        nivel_prox = decodifica_nivel(32'(ocupacao), CAP_MAX);
    end

    // A new error in the same cycle as a clear request must survive the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ocupacao         <= ZERO;
            capacidade_atual <= CAP_VAZIO;
            erro_contagem    <= 1'b0;
        end else begin
            ocupacao         <= ocupacao_prox;
            capacidade_atual <= nivel_prox;
            erro_contagem    <= erro_evento | (erro_contagem & ~limpar_erro);
        end
    end

endmodule
